// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg -- shared types and widths for the instruction-memory loader.
//   state_t : loader FSM state encoding
//   HDR_W   : width of the word-count header
//   WORD_W  : instruction word / memory address width
//   BYTE_W  : stream byte width
package imem_loader_pkg;

    localparam int HDR_W  = 16;
    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_HI,
        ST_HDR_LO,
        ST_PAYLOAD,
        ST_WRITE,
        ST_CHECK,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if -- byte stream in, instruction-memory write port out.
//   byte_valid / byte_data : stream source -> loader
//   byte_ready             : loader -> source, transfer on valid && ready
//   mem_we / mem_addr / mem_wdata : loader -> instruction memory
// The loader uses the slave modport; the stream source / memory side uses master.
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic              byte_valid;
    logic [BYTE_W-1:0] byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// imem_byte_packer -- assembles four stream bytes (MSB first) into one word.
//   clk, rst     : clock, synchronous active-low reset
//   clear        : restart assembly at byte 0
//   shift_en     : accept byte_in this cycle
//   byte_in      : stream byte
//   word         : assembled word (valid once four bytes have been shifted in)
//   last_byte    : the next accepted byte completes the word
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic              last_byte
);

    logic [1:0] byte_idx;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            word     <= '0;
            byte_idx <= '0;
        end else if (shift_en) begin
            word     <= {word[WORD_W-BYTE_W-1:0], byte_in};
            byte_idx <= byte_idx + 2'd1;
        end
    end

    assign last_byte = (byte_idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// imem_loader -- loads a length-prefixed, XOR-checksummed program stream into
// instruction memory and holds the CPU in reset until a good load completes.
//   clk, rst  : clock, synchronous active-low reset
//   start     : begin a load (only from IDLE, DONE, ERR)
//   bus       : byte stream in / memory write port out (imem_loader_if.slave)
//   cpu_rst   : high while no valid program is loaded
//   done      : load finished with a matching checksum
//   error     : load aborted (oversize header or bad checksum)
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   ST_IDLE    | out of reset, waiting for start
//   ST_HDR_HI  | waiting for word-count MSB
//   ST_HDR_LO  | waiting for word-count LSB, then range check
//   ST_PAYLOAD | collecting the four bytes of the current word
//   ST_WRITE   | one-cycle memory write of the assembled word
//   ST_CHECK   | waiting for the checksum byte
//   ST_DONE    | good load, CPU released
//   ST_ERR     | load aborted, CPU held in reset
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [WORD_W-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int                MAX_WORDS = 256
)
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    imem_loader_if.slave   bus,
    output logic           cpu_rst,
    output logic           done,
    output logic           error
);

    localparam logic [WORD_W-1:0] MAX_W = WORD_W'(MAX_WORDS);

    state_t            state, state_next;
    logic [BYTE_W-1:0] hdr_hi;
    logic [HDR_W-1:0]  word_cnt;
    logic [HDR_W-1:0]  word_idx;
    logic [BYTE_W-1:0] csum;
    logic [WORD_W-1:0] word;
    logic              last_byte;
    logic              xfer;
    logic              start_ok;
    logic [HDR_W-1:0]  hdr_full;
    logic [HDR_W:0]    idx_inc;

    assign start_ok = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    assign bus.byte_ready = (state == ST_HDR_HI) || (state == ST_HDR_LO)
                         || (state == ST_PAYLOAD) || (state == ST_CHECK);
    assign xfer     = bus.byte_valid && bus.byte_ready;
    assign hdr_full = {hdr_hi, bus.byte_data};
    // One wider than the count so i+1 never wraps at N = 0xFFFF.
    assign idx_inc  = {1'b0, word_idx} + (HDR_W+1)'(1);

    imem_byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_ok),
        .shift_en  (xfer && state == ST_PAYLOAD),
        .byte_in   (bus.byte_data),
        .word      (word),
        .last_byte (last_byte)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR:
                if (start) state_next = ST_HDR_HI;
            ST_HDR_HI:
                if (xfer) state_next = ST_HDR_LO;
            ST_HDR_LO:
                if (xfer) begin
                    if ({{(WORD_W-HDR_W){1'b0}}, hdr_full} > MAX_W) state_next = ST_ERR;
                    else if (hdr_full == '0)                        state_next = ST_CHECK;
                    else                                            state_next = ST_PAYLOAD;
                end
            ST_PAYLOAD:
                if (xfer && last_byte) state_next = ST_WRITE;
            ST_WRITE:
                state_next = (idx_inc < {1'b0, word_cnt}) ? ST_PAYLOAD : ST_CHECK;
            ST_CHECK:
                if (xfer) state_next = (bus.byte_data == csum) ? ST_DONE : ST_ERR;
            default:
                state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hdr_hi   <= '0;
            word_cnt <= '0;
            word_idx <= '0;
            csum     <= '0;
        end else if (start_ok) begin
            hdr_hi   <= '0;
            word_cnt <= '0;
            word_idx <= '0;
            csum     <= '0;
        end else begin
            case (state)
                ST_HDR_HI:  if (xfer) hdr_hi   <= bus.byte_data;
                ST_HDR_LO:  if (xfer) word_cnt <= hdr_full;
                ST_PAYLOAD: if (xfer) csum     <= csum ^ bus.byte_data;
                ST_WRITE:   word_idx <= word_idx + HDR_W'(1);
                default: ;
            endcase
        end
    end

    // Address/data are forced to zero outside WRITE so the port reads all-zero in reset.
    assign bus.mem_we    = (state == ST_WRITE);
    assign bus.mem_addr  = bus.mem_we
                         ? BASE_ADDR + {{(WORD_W-HDR_W-2){1'b0}}, word_idx, 2'b00}
                         : '0;
    assign bus.mem_wdata = bus.mem_we ? word : '0;

    assign cpu_rst = (state != ST_DONE);
    assign done    = (state == ST_DONE);
    assign error   = (state == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader -- directed + randomized stream tests for imem_loader.
// Two instances: dut0 (defaults) and dut1 (BASE_ADDR 0x100, MAX_WORDS 8).
// Expected writes and the final verdict come from parsing each stream directly.
module tb_imem_loader;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    logic cpu0, done0, err0, cpu1, done1, err1;

    imem_loader_if if0();
    imem_loader_if if1();

    imem_loader dut0 (
        .clk(clk), .rst(rst), .start(start0), .bus(if0.slave),
        .cpu_rst(cpu0), .done(done0), .error(err0)
    );

    imem_loader #(.BASE_ADDR(32'h0000_0100), .MAX_WORDS(8)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .bus(if1.slave),
        .cpu_rst(cpu1), .done(done1), .error(err1)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int sel    = 0;

    logic        o_ready, o_we, o_done, o_err, o_cpu;
    logic [31:0] o_addr, o_data;

    always_comb begin
        if (sel == 1) begin
            o_ready = if1.byte_ready; o_we = if1.mem_we;
            o_addr  = if1.mem_addr;   o_data = if1.mem_wdata;
            o_done  = done1; o_err = err1; o_cpu = cpu1;
        end else begin
            o_ready = if0.byte_ready; o_we = if0.mem_we;
            o_addr  = if0.mem_addr;   o_data = if0.mem_wdata;
            o_done  = done0; o_err = err0; o_cpu = cpu0;
        end
    end

    logic [7:0]  stim[$];
    logic [31:0] exp_wa[$];
    logic [31:0] exp_wd[$];
    bit          exp_ok;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic set_valid(input bit v);
        if (sel == 1) if1.byte_valid = v; else if0.byte_valid = v;
    endtask

    task automatic set_start(input bit s);
        if (sel == 1) start1 = s; else start0 = s;
    endtask

    // Reference: parse the stream as the format defines it.
    function automatic void model();
        logic [31:0] base;
        int          maxw, n;
        logic [7:0]  x;
        logic [31:0] d;
        base = (sel == 1) ? 32'h0000_0100 : 32'h0;
        maxw = (sel == 1) ? 8 : 256;
        exp_wa.delete();
        exp_wd.delete();
        n = {16'h0, stim[0], stim[1]};
        if (n > maxw) begin
            exp_ok = 1'b0;
            return;
        end
        x = 8'h00;
        for (int w = 0; w < n; w++) begin
            d = {stim[2+4*w], stim[3+4*w], stim[4+4*w], stim[5+4*w]};
            x = x ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
            exp_wa.push_back(base + 32'(4*w));
            exp_wd.push_back(d);
        end
        exp_ok = (stim[2+4*n] == x);
    endfunction

    task automatic build(input int n, input bit good);
        logic [7:0] x, b;
        logic [15:0] nn;
        nn = n[15:0];
        x = 8'h00;
        stim.delete();
        stim.push_back(nn[15:8]);
        stim.push_back(nn[7:0]);
        for (int i = 0; i < 4*n; i++) begin
            b = 8'($urandom);
            x = x ^ b;
            stim.push_back(b);
        end
        stim.push_back(good ? x : (x ^ 8'h5A));
    endtask

    // Starts a load on the selected DUT and feeds stim. limit>0 stops after that many bytes.
    task automatic run(input bit hold, input int limit, input bit poke);
        int idx, nw;
        bit tail, fin, v;
        model();
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        idx = 0; nw = 0; tail = 0; fin = 0;
        for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
            if (o_we) begin
                chk("ready_low_in_write", {31'h0, o_ready}, 32'h0);
                if (nw < exp_wa.size()) begin
                    chk("wr_addr", o_addr, exp_wa[nw]);
                    chk("wr_data", o_data, exp_wd[nw]);
                end
                nw++;
            end
            if (tail) begin
                set_valid(1'b0);
                set_start(1'b0);
                fin = 1;
                if (limit == 0) begin
                    chk("write_count", 32'(nw), 32'(exp_wa.size()));
                    chk("done",    {31'h0, o_done}, {31'h0, exp_ok});
                    chk("error",   {31'h0, o_err},  {31'h0, !exp_ok});
                    chk("cpu_rst", {31'h0, o_cpu},  {31'h0, !exp_ok});
                    chk("ready_after", {31'h0, o_ready}, 32'h0);
                    set_valid(1'b1);
                    repeat (3) @(negedge clk);
                    chk("sticky_done",  {31'h0, o_done}, {31'h0, exp_ok});
                    chk("sticky_error", {31'h0, o_err},  {31'h0, !exp_ok});
                    chk("sticky_no_we", {31'h0, o_we},   32'h0);
                    set_valid(1'b0);
                end
            end else begin
                v = hold || ($urandom_range(0, 99) < 65);
                if0.byte_data = stim[idx];
                if1.byte_data = stim[idx];
                set_valid(v);
                set_start(poke && idx == 4);
                if (v && o_ready) begin
                    idx++;
                    if (idx == stim.size() || idx == limit) tail = 1;
                end
                @(negedge clk);
            end
        end
        chk("stream_completed", {31'h0, fin}, 32'h1);
    endtask

    task automatic check_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            chk("rst_ready", {31'h0, o_ready}, 32'h0);
            chk("rst_we",    {31'h0, o_we},    32'h0);
            chk("rst_addr",  o_addr,           32'h0);
            chk("rst_wdata", o_data,           32'h0);
            chk("rst_cpu",   {31'h0, o_cpu},   32'h1);
            chk("rst_done",  {31'h0, o_done},  32'h0);
            chk("rst_error", {31'h0, o_err},   32'h0);
        end
    endtask

    initial begin
        if0.byte_valid = 1'b0; if0.byte_data = 8'h00;
        if1.byte_valid = 1'b0; if1.byte_data = 8'h00;
        repeat (3) @(negedge clk);
        check_reset();
        rst = 1'b1;
        @(negedge clk);

        sel = 0;
        stim = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        run(1'b1, 0, 1'b0);
        stim = '{8'h00, 8'h00, 8'h00};
        run(1'b1, 0, 1'b0);
        stim = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23};
        run(1'b1, 0, 1'b0);
        stim = '{8'h01, 8'h01};
        run(1'b1, 0, 1'b0);

        sel = 1;
        build(2, 1'b1);
        run(1'b1, 0, 1'b0);
        build(8, 1'b1);
        run(1'b0, 0, 1'b0);
        stim = '{8'h00, 8'h09};
        run(1'b0, 0, 1'b0);

        sel = 0;
        for (int t = 0; t < 6; t++) begin
            build(int'($urandom_range(1, 6)), (t != 2 && t != 5));
            run(1'b0, 0, (t == 1 || t == 4));
        end

        sel = 1;
        build(3, 1'b1);
        run(1'b0, 7, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_reset();
        rst = 1'b1;
        sel = 1;
        @(negedge clk);
        build(1, 1'b1);
        run(1'b0, 0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
